// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage types: M-extension multiply op encodings and the
// sequential multiplier's state encoding.
package rv32_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mul_state_t;

    function automatic logic rs1_is_signed(mul_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic rs2_is_signed(mul_op_t op);
        return op == OP_MULH;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// EX-stage <-> sequential multiplier request/response bundle.
interface seq_multiplier_if #(
    parameter int XLEN = 32
);
    import rv32_pkg::*;

    logic            start;
    logic            kill;
    mul_op_t         op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, op, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, rs1, rs2,
        output busy, done, result
    );

endinterface

// File: rtl/seq_multiplier_rca.sv
// Parameterised ripple-carry adder: {cout, sum} = a + b + cin.
module seq_multiplier_rca #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic cy;
        cy  = cin;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        cout = cy;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU: multiplies operand
// magnitudes over XLEN steps, then applies the sign in a single fix-up cycle.
module seq_multiplier
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic              clk,
    input logic              rst,
    seq_multiplier_if.slave  bus
);

    mul_state_t        state, state_nx;
    mul_op_t           op_q;
    logic [XLEN-1:0]   m, q, a;
    logic              neg;
    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   result_q;
    logic              accept;

    logic [XLEN-1:0]   addend, sum;
    logic              carry;
    logic [2*XLEN-1:0] prod, prod_fix;

    logic              s1, s2;
    logic [XLEN-1:0]   rs1_mag, rs2_mag;

    // Magnitude of each operand as it will be latched; |min| stays min as unsigned.
    always_comb begin
        s1      = rs1_is_signed(bus.op) & bus.rs1[XLEN-1];
        s2      = rs2_is_signed(bus.op) & bus.rs2[XLEN-1];
        rs1_mag = s1 ? (~bus.rs1 + XLEN'(1)) : bus.rs1;
        rs2_mag = s2 ? (~bus.rs2 + XLEN'(1)) : bus.rs2;
    end

    assign addend = q[0] ? m : '0;

    seq_multiplier_rca #(.n(XLEN)) u_rca (
        .a    (a),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    assign prod     = {a, q};
    assign prod_fix = neg ? (~prod + (2*XLEN)'(1)) : prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start && !bus.kill) begin
                    state_nx = S_CALC;
                    accept   = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_CALC: begin
                if (bus.kill)                           state_nx = S_IDLE;
                else if (count == CNT_W'(XLEN - 1))     state_nx = S_FIX;
            end
            S_FIX:   state_nx = bus.kill ? S_IDLE : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_MUL;
            m        <= '0;
            q        <= '0;
            a        <= '0;
            neg      <= 1'b0;
            count    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q  <= bus.op;
            m     <= rs1_mag;
            q     <= rs2_mag;
            a     <= '0;
            neg   <= s1 ^ s2;
            count <= '0;
        end else if (state == S_CALC && !bus.kill) begin
            {a, q} <= {carry, sum, q[XLEN-1:1]};
            count  <= count + CNT_W'(1);
        end else if (state == S_FIX && !bus.kill) begin
            result_q <= (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    assign bus.busy   = (state == S_CALC) || (state == S_FIX);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed corners plus randomized ops
// checked against a 64-bit arithmetic reference model.
module tb_seq_multiplier;
    import rv32_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] res;
        int              cyc;
        string           name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier_if #(.XLEN(XLEN)) bus ();

    seq_multiplier #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [XLEN-1:0] ref_mul(mul_op_t op, logic [XLEN-1:0] x, logic [XLEN-1:0] y);
        logic signed [63:0] xe, ye, p;
        xe = (op == OP_MULH || op == OP_MULHSU) ? {{32{x[31]}}, x} : {32'b0, x};
        ye = (op == OP_MULH) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = xe * ye;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done at cycle %0d with no request outstanding", cyc);
            end else begin
                e = sb.pop_front();
                chk(e.name, bus.result, e.res);
                chk({e.name, "_latency"}, 32'(cyc - e.cyc), 32'(XLEN + 2));
            end
        end
    end

    // Called just after a negedge; start is sampled at the next posedge.
    task automatic issue(mul_op_t op, logic [XLEN-1:0] x, logic [XLEN-1:0] y, string name);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = x;
        bus.rs2   = y;
        e.res  = ref_mul(op, x, y);
        e.cyc  = cyc;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
        end
        if (i == 60) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nbusy;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op    = OP_MUL;
        bus.rs1   = '0;
        bus.rs2   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic MUL with busy-window measurement.
        issue(OP_MUL, 32'd7, 32'd6, "mul_7x6");
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(nbusy), 32'd33);
        drain();

        issue(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1xm1");    drain();
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");     drain();
        issue(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1xm1");     drain();
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");     drain();
        issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_minxmin");  drain();
        issue(OP_MULH,   32'h8000_0000, 32'h0000_0001, "mulh_minx1");    drain();
        issue(OP_MULH,   32'h0000_0000, 32'hFFFF_FFFF, "mulh_zero_neg"); drain();

        // Kill in CALC cycle 10: no done, result keeps the previous value.
        issue(OP_MUL, 32'h1234, 32'h10, "mul_pre_kill"); drain();
        issue(OP_MUL, 32'd9, 32'd9, "mul_killed");
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        bus.kill = 1'b0;
        chk("kill_busy", 32'(bus.busy), 32'd0);
        chk("kill_result_held", bus.result, 32'h0001_2340);
        repeat (40) @(negedge clk);
        issue(OP_MUL, 32'd3, 32'd5, "mul_after_kill"); drain();

        // start while busy is ignored.
        issue(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, "mulhu_busy_start");
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.rs1   = 32'd11;
        bus.rs2   = 32'd13;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Asynchronous reset between edges mid-CALC.
        issue(OP_MUL, 32'd100, 32'd200, "mul_reset_victim");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_done", 32'(bus.done), 32'd0);
        chk("async_rst_result", bus.result, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Back-to-back: new start in the DONE cycle.
        issue(OP_MUL, 32'd2, 32'd2, "b2b_first");
        wait_done();
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'h2, "b2b_second");
        drain();

        // kill in DONE suppresses a simultaneous start but done still shows.
        issue(OP_MUL, 32'd4, 32'd4, "mul_done_kill");
        wait_done();
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        chk("done_kill_no_accept", 32'(bus.busy), 32'd0);
        repeat (40) @(negedge clk);

        // Randomized traffic, mixing idle gaps and back-to-back starts.
        for (int n = 0; n < 30; n++) begin
            issue(mul_op_t'($urandom_range(0, 3)), pick(), pick(), $sformatf("rand_%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                wait_done();
            end else begin
                drain();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
